hsiao_secded_scrub_memory: RTL and testbench
============================================

Name: hsiao_secded_scrub_memory

Overview:
Parametrised successor to the team's fixed 8-bit Hsiao fault-injection memory. It is a DATA_W-wide, DEPTH-entry SEC-DED protected RAM with:
- a one-cycle registered read port with valid flag;
- persistent write-path fault injection;
- a post-reset zero-initialisation sweep;
- a background scrubber that reads every word and writes back single-bit-corrected codewords;
- saturating error counters.

It sits between a simple requester and storage, and is the reference target for error-tolerance experiments.

Parameters:
DATA_W, 8, data width; legal values 8, 16, 32.
CHK_W, 5/6/7, check bits; derived from DATA_W (8→5, 16→6, 32→7); not user-overridable.
ADDR_W, 3, address width; DEPTH = 2**ADDR_W.
SCRUB_INTERVAL, 16, idle cycles between scrub reads; ≥2.
CNT_W, 16, width of the error counters.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  asynchronous, active-low reset.
wr_en  in  1  write request.
rd_en  in  1  read request.
addr  in  ADDR_W  shared read/write address.
wr_data  in  DATA_W  write data.
inj_mask  in  DATA_W+CHK_W  XORed into the codeword stored on a write.
scrub_en  in  1  enables the background scrubber.
cnt_clr  in  1  synchronous clear of both counters.
rd_data  out  DATA_W  corrected read data.
rd_valid  out  1  pulses for one cycle when rd_data is valid.
sec  out  1  single error corrected on this read; qualified by rd_valid.
ded  out  1  uncorrectable error on this read; qualified by rd_valid.
init_busy  out  1  high during the post-reset zeroing sweep.
cnt_sec  out  CNT_W  saturating count of corrected errors.
cnt_ded  out  CNT_W  saturating count of uncorrectable errors.

Behaviour:
- Codeword layout: {check[CHK_W-1:0], data[DATA_W-1:0]}, data in the low bits.
- H-matrix:
  - data bit i uses the i-th weight-3 CHK_W-bit vector in ascending numeric order;
  - check bit j uses the unit vector e_j.
  - check = H_data·data (XOR per row).
- Reset (rst=0, asynchronous):
  - rd_valid, sec, ded, rd_data, cnt_sec and cnt_ded are cleared to 0.
  - init_busy is set to 1, the FSM enters INIT, and the INIT pointer is set to 0.
  - Reset mid-operation aborts everything and restarts INIT.
- INIT state:
  - Writes the all-zero codeword (a valid codeword) to one address per cycle, from 0 up to DEPTH-1.
  - init_busy drops the cycle after the last write; the FSM then goes to IDLE.
  - User wr_en and rd_en are ignored during INIT, and rd_valid stays 0.
- User write:
  - In the cycle wr_en=1, the memory stores {enc(wr_data)} ^ inj_mask at addr.
- User read:
  - rd_en=1 in cycle N gives rd_valid=1 in cycle N+1, with rd_data, sec and ded decoded from the stored codeword.
- Simultaneous wr_en and rd_en: the write executes and the read is dropped (no rd_valid).
- Decode, by syndrome s:
  - s=0: clean.
  - s equals a column of H: flip that bit, sec=1. A check-bit column gives sec=1 with data unchanged.
  - s nonzero and not a column (even weight, or odd weight matching no column): ded=1 and rd_data = raw stored data.
- Scrubber FSM, states IDLE → WAIT → SREAD → SCHECK → [SWB] → IDLE:
  - WAIT counts SCRUB_INTERVAL cycles while scrub_en=1. When scrub_en=0, the FSM holds in IDLE and keeps its pointer.
  - SREAD issues an internal read of scrub_ptr only in a cycle with no user wr_en/rd_en; otherwise it stalls.
  - SCHECK decodes the word:
    - sec → SWB;
    - clean → IDLE;
    - ded → IDLE with no writeback.
    - In all three cases scrub_ptr increments, wrapping DEPTH-1→0.
  - SWB writes back the corrected codeword in the first cycle with no user access.
  - If a user write hits the same address while the FSM is in SCHECK or SWB, the writeback is cancelled.
  - Scrub reads never assert rd_valid.
- Counters:
  - Both user and scrub reads increment cnt_sec or cnt_ded.
  - Counters saturate at all-ones.
  - cnt_clr has priority over a same-cycle increment.

Optional Feature:
HSIAO_ERR_LOG_EN:
- When defined, adds three outputs:
  - err_log_valid (1);
  - err_log_addr (ADDR_W);
  - err_log_syn (CHK_W).
- These capture the address and syndrome of the first ded event (user or scrub) after reset or cnt_clr.
- The log holds until cleared, and later ded events do not overwrite it.
- When not defined, these ports and their logic are absent and all other behaviour is identical.

Test Plan:
- Reset, then wait: init_busy=1 for exactly 8 cycles (DEPTH=8); then reading addr 0..7 returns 0x00 with sec=0, ded=0.
- Write 0xA5 to addr 3 with inj_mask=0, rd_en addr 3: rd_valid exactly one cycle later, rd_data=0xA5, sec=0, ded=0.
- For each of the 13 bits k, write 0x3C to addr 1 with inj_mask=1<<k and read: rd_data=0x3C, sec=1, ded=0; cnt_sec ends at 13.
- For every pair k1<k2 (78 pairs), write 0xFF with a two-bit inj_mask and read: ded=1, sec=0 every time; cnt_ded=78.
- Write 0x5A to addr 5 with inj_mask=0x010, scrub_en=1, wait ≥ 8×(SCRUB_INTERVAL+4) cycles with no user traffic, then read addr 5: rd_data=0x5A, sec=0; cnt_sec=1.
- Hold rd_en=1 continuously while scrub_en=1: the scrubber makes no progress (its stall is visible via unchanged counters on a pre-corrupted word); after rd_en drops, the scrub completes and corrects the word.

Source files
------------

// File: rtl/hsiao_secded_scrub_memory.sv
// hsiao_secded_scrub_memory: DATA_W-wide, 2**ADDR_W-deep Hsiao SEC-DED RAM.
// It has a registered read port, write-path fault injection, a zeroing sweep
// after reset, a background scrubber and saturating error counters.
// Optional error log: define HSIAO_ERR_LOG_EN.
// Ports:
//   clk, rst (async, active-low)
//   wr_en, rd_en, addr, wr_data, inj_mask  - requester side; inj_mask is XORed
//                                            into the stored codeword
//   scrub_en, cnt_clr                      - scrubber enable, counter clear
//   rd_data, rd_valid, sec, ded            - registered read result
//   init_busy                              - zeroing sweep in progress
//   cnt_sec, cnt_ded                       - saturating error counters
//   err_log_valid/addr/syn                 - first ded capture (HSIAO_ERR_LOG_EN)
module hsiao_secded_scrub_memory #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ADDR_W         = 3,
  parameter int unsigned SCRUB_INTERVAL = 16,
  parameter int unsigned CNT_W          = 16,
  localparam int unsigned CHK_W = (DATA_W <= 8) ? 5 : ((DATA_W <= 16) ? 6 : 7)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [DATA_W+CHK_W-1:0] inj_mask,
  input  logic                    scrub_en,
  input  logic                    cnt_clr,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rd_valid,
  output logic                    sec,
  output logic                    ded,
  output logic                    init_busy,
  output logic [CNT_W-1:0]        cnt_sec,
  output logic [CNT_W-1:0]        cnt_ded
`ifdef HSIAO_ERR_LOG_EN
  ,
  output logic                    err_log_valid,
  output logic [ADDR_W-1:0]       err_log_addr,
  output logic [CHK_W-1:0]        err_log_syn
`endif
);

  localparam int unsigned CW     = DATA_W + CHK_W;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned WAIT_W = $clog2(SCRUB_INTERVAL);
  localparam int unsigned CNT_X  = CNT_W + 1;

  typedef logic [DATA_W-1:0][CHK_W-1:0] hcols_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sec;
    logic              ded;
  } dec_t;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_WAIT, S_SREAD, S_SCHECK, S_SWB} state_t;

  // Data columns: the weight-3 CHK_W-bit vectors in ascending numeric order.
  function automatic hcols_t gen_cols();
    hcols_t      cols;
    int unsigned n;
    cols = '0;
    n    = 0;
    for (int unsigned v = 0; v < (32'd1 << CHK_W); v++) begin
      if ($countones(v[CHK_W-1:0]) == 3 && n < DATA_W) begin
        cols[n] = v[CHK_W-1:0];
        n++;
      end
    end
    return cols;
  endfunction

  localparam hcols_t H_COLS = gen_cols();

  function automatic logic [CHK_W-1:0] enc(input logic [DATA_W-1:0] d);
    logic [CHK_W-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (d[i]) c = c ^ H_COLS[i];
    end
    return c;
  endfunction

  function automatic logic [CHK_W-1:0] syndrome(input logic [CW-1:0] cw);
    return cw[CW-1:DATA_W] ^ enc(cw[DATA_W-1:0]);
  endfunction

  // Data-column hit flips that bit; unit syndrome is a check-bit error; any other
  // nonzero syndrome is uncorrectable and the raw data is passed through.
  function automatic dec_t dec(input logic [CW-1:0] cw);
    dec_t             r;
    logic [CHK_W-1:0] s;
    logic             hit;
    s      = syndrome(cw);
    r.data = cw[DATA_W-1:0];
    hit    = ($countones(s) == 1);
    for (int i = 0; i < DATA_W; i++) begin
      if (s == H_COLS[i]) begin
        r.data[i] = ~r.data[i];
        hit       = 1'b1;
      end
    end
    r.sec = (s != '0) && hit;
    r.ded = (s != '0) && !hit;
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                               input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, c} + CNT_X'(inc);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  logic [CW-1:0]     mem [DEPTH];
  state_t            state;
  logic [ADDR_W-1:0] init_ptr;
  logic [ADDR_W-1:0] scrub_ptr;
  logic [ADDR_W-1:0] wb_addr;
  logic [CW-1:0]     wb_cw;
  logic [CW-1:0]     scrub_cw;
  logic [WAIT_W-1:0] wait_cnt;

  dec_t              user_dec;
  dec_t              scrub_dec;
  logic              user_rd;
  logic              scrub_chk;
  logic [1:0]        sec_inc;
  logic [1:0]        ded_inc;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [CW-1:0]     mem_wdata;

  assign user_dec  = dec(mem[addr]);
  assign scrub_dec = dec(scrub_cw);
  assign user_rd   = rd_en && !wr_en && (state != S_INIT);
  assign scrub_chk = (state == S_SCHECK);
  assign sec_inc   = {1'b0, user_rd & user_dec.sec} + {1'b0, scrub_chk & scrub_dec.sec};
  assign ded_inc   = {1'b0, user_rd & user_dec.ded} + {1'b0, scrub_chk & scrub_dec.ded};

  // Single write port: init sweep, then user write, then scrub writeback.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = '0;
    if (state == S_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = init_ptr;
    end else if (wr_en) begin
      mem_we    = 1'b1;
      mem_wdata = {enc(wr_data), wr_data} ^ inj_mask;
    end else if (state == S_SWB && !rd_en) begin
      mem_we    = 1'b1;
      mem_waddr = wb_addr;
      mem_wdata = wb_cw;
    end
  end

  // Storage array; contents are established by the init sweep, not by reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Control FSM, read port and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_INIT;
      init_ptr  <= '0;
      init_busy <= 1'b1;
      scrub_ptr <= '0;
      wb_addr   <= '0;
      wb_cw     <= '0;
      scrub_cw  <= '0;
      wait_cnt  <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      sec       <= 1'b0;
      ded       <= 1'b0;
      cnt_sec   <= '0;
      cnt_ded   <= '0;
    end else begin
      rd_valid <= user_rd;
      sec      <= user_rd & user_dec.sec;
      ded      <= user_rd & user_dec.ded;
      if (user_rd) rd_data <= user_dec.data;

      if (cnt_clr) begin
        cnt_sec <= '0;
        cnt_ded <= '0;
      end else begin
        cnt_sec <= sat_add(cnt_sec, sec_inc);
        cnt_ded <= sat_add(cnt_ded, ded_inc);
      end

      case (state)
        S_INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (init_ptr == ADDR_W'(DEPTH - 1)) begin
            init_busy <= 1'b0;
            state     <= S_IDLE;
          end
        end
        S_IDLE: begin
          wait_cnt <= '0;
          if (scrub_en) state <= S_WAIT;
        end
        S_WAIT: begin
          if (!scrub_en) begin
            state <= S_IDLE;
          end else if (wait_cnt == WAIT_W'(SCRUB_INTERVAL - 1)) begin
            state <= S_SREAD;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_SREAD: begin
          // Scrub read only takes a cycle with no user access.
          if (!scrub_en) begin
            state <= S_IDLE;
          end else if (!wr_en && !rd_en) begin
            scrub_cw <= mem[scrub_ptr];
            state    <= S_SCHECK;
          end
        end
        S_SCHECK: begin
          scrub_ptr <= scrub_ptr + 1'b1;
          wb_addr   <= scrub_ptr;
          wb_cw     <= {enc(scrub_dec.data), scrub_dec.data};
          // A same-cycle user write to this word makes the snapshot stale.
          if (scrub_dec.sec && !(wr_en && addr == scrub_ptr)) state <= S_SWB;
          else state <= S_IDLE;
        end
        S_SWB: begin
          if (wr_en) begin
            if (addr == wb_addr) state <= S_IDLE;
          end else if (!rd_en) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef HSIAO_ERR_LOG_EN
  // First uncorrectable event since reset or counter clear; user read wins a tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_log_valid <= 1'b0;
      err_log_addr  <= '0;
      err_log_syn   <= '0;
    end else if (cnt_clr) begin
      err_log_valid <= 1'b0;
      err_log_addr  <= '0;
      err_log_syn   <= '0;
    end else if (!err_log_valid) begin
      if (user_rd && user_dec.ded) begin
        err_log_valid <= 1'b1;
        err_log_addr  <= addr;
        err_log_syn   <= syndrome(mem[addr]);
      end else if (scrub_chk && scrub_dec.ded) begin
        err_log_valid <= 1'b1;
        err_log_addr  <= scrub_ptr;
        err_log_syn   <= syndrome(scrub_cw);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hsiao_secded_scrub_memory.sv
// Directed self-checking bench for hsiao_secded_scrub_memory (default parameters).
module tb_hsiao_secded_scrub_memory;

  localparam int unsigned CW = 13;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic          rd_en;
  logic [2:0]    addr;
  logic [7:0]    wr_data;
  logic [CW-1:0] inj_mask;
  logic          scrub_en;
  logic          cnt_clr;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          sec;
  logic          ded;
  logic          init_busy;
  logic [15:0]   cnt_sec;
  logic [15:0]   cnt_ded;
`ifdef HSIAO_ERR_LOG_EN
  logic          err_log_valid;
  logic [2:0]    err_log_addr;
  logic [4:0]    err_log_syn;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  hsiao_secded_scrub_memory dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .addr      (addr),
    .wr_data   (wr_data),
    .inj_mask  (inj_mask),
    .scrub_en  (scrub_en),
    .cnt_clr   (cnt_clr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .sec       (sec),
    .ded       (ded),
    .init_busy (init_busy),
    .cnt_sec   (cnt_sec),
    .cnt_ded   (cnt_ded)
`ifdef HSIAO_ERR_LOG_EN
    ,
    .err_log_valid (err_log_valid),
    .err_log_addr  (err_log_addr),
    .err_log_syn   (err_log_syn)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d, input logic [CW-1:0] m);
    @(negedge clk);
    wr_en = 1'b1; addr = a; wr_data = d; inj_mask = m;
    @(negedge clk);
    wr_en = 1'b0; inj_mask = '0;
  endtask

  // Returns {rd_valid, sec, ded, rd_data} sampled one cycle after rd_en.
  task automatic do_read(input logic [2:0] a, output logic [10:0] res);
    @(negedge clk);
    rd_en = 1'b1; addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    res = {rd_valid, sec, ded, rd_data};
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] r;
    int          n;
    logic        seen_valid;

    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wr_data = '0;
    inj_mask = '0; scrub_en = 1'b0; cnt_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", 32'({rd_valid, sec, ded, rd_data}), 32'(0));
    check("rst_init_busy", 32'(init_busy), 32'(1));
    check("rst_counters", {cnt_sec, cnt_ded}, 32'(0));

    // Release reset; user reads requested during the sweep must be ignored.
    rst = 1'b1;
    rd_en = 1'b1;
    n = 0;
    seen_valid = 1'b0;
    while (init_busy && n < 100) begin
      n++;
      @(negedge clk);
      seen_valid = seen_valid | rd_valid;
    end
    rd_en = 1'b0;
    check("init_busy_cycles", 32'(n), 32'(8));
    check("init_no_rd_valid", 32'(seen_valid), 32'(0));

    for (int a = 0; a < 8; a++) begin
      do_read(3'(a), r);
      check("init_zero_rd", 32'(r), 32'({1'b1, 1'b0, 1'b0, 8'h00}));
    end

    // Clean write/read with exact one-cycle latency.
    do_write(3'd3, 8'hA5, '0);
    @(negedge clk);
    rd_en = 1'b1; addr = 3'd3;
    check("rd_valid_before", 32'(rd_valid), 32'(0));
    @(negedge clk);
    rd_en = 1'b0;
    check("clean_rd", 32'({rd_valid, sec, ded, rd_data}), 32'({1'b1, 1'b0, 1'b0, 8'hA5}));
    @(negedge clk);
    check("rd_valid_pulse", 32'(rd_valid), 32'(0));

    // Every single-bit error (8 data + 5 check) is corrected.
    for (int k = 0; k < 13; k++) begin
      do_write(3'd1, 8'h3C, CW'(1) << k);
      do_read(3'd1, r);
      check("single_err_rd", 32'(r), 32'({1'b1, 1'b1, 1'b0, 8'h3C}));
    end
    check("cnt_sec_13", 32'(cnt_sec), 32'(13));
    check("cnt_ded_0", 32'(cnt_ded), 32'(0));

    // Every double-bit error is detected, never miscorrected.
    for (int k1 = 0; k1 < 13; k1++) begin
      for (int k2 = k1 + 1; k2 < 13; k2++) begin
        do_write(3'd2, 8'hFF, (CW'(1) << k1) | (CW'(1) << k2));
        do_read(3'd2, r);
        check("double_err_flags", 32'(r[10:8]), 32'(3'b101));
      end
    end
    check("cnt_ded_78", 32'(cnt_ded), 32'(78));
    check("cnt_sec_hold", 32'(cnt_sec), 32'(13));
`ifdef HSIAO_ERR_LOG_EN
    // First ded was bits 0 and 1 at addr 2: syndrome 5'b00111 ^ 5'b01011.
    check("errlog", 32'({err_log_valid, err_log_addr, err_log_syn}),
          32'({1'b1, 3'd2, 5'h0C}));
`endif

    // Counter clear, then clear beats a same-cycle increment.
    pulse_clr();
    check("cnt_clr", {cnt_sec, cnt_ded}, 32'(0));
    do_write(3'd1, 8'h3C, CW'(1));
    @(negedge clk);
    rd_en = 1'b1; addr = 3'd1; cnt_clr = 1'b1;
    @(negedge clk);
    rd_en = 1'b0; cnt_clr = 1'b0;
    check("clr_priority_sec", 32'(sec), 32'(1));
    check("clr_priority_cnt", 32'(cnt_sec), 32'(0));

    // Write and read together: write wins, no rd_valid.
    @(negedge clk);
    wr_en = 1'b1; rd_en = 1'b1; addr = 3'd4; wr_data = 8'h99;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    check("wr_rd_no_valid", 32'(rd_valid), 32'(0));
    do_read(3'd4, r);
    check("wr_rd_data", 32'(r), 32'({1'b1, 1'b0, 1'b0, 8'h99}));

    // Scrubber corrects a single-bit error with no user traffic.
    do_write(3'd1, 8'h3C, '0);
    do_write(3'd2, 8'hFF, '0);
    pulse_clr();
    do_write(3'd5, 8'h5A, CW'(13'h010));
    @(negedge clk);
    scrub_en = 1'b1;
    repeat (8 * (16 + 4) + 40) @(negedge clk);
    scrub_en = 1'b0;
    repeat (5) @(negedge clk);
    check("scrub_cnt_sec", 32'(cnt_sec), 32'(1));
    check("scrub_cnt_ded", 32'(cnt_ded), 32'(0));
    do_read(3'd5, r);
    check("scrub_fixed", 32'(r), 32'({1'b1, 1'b0, 1'b0, 8'h5A}));

    // Continuous user reads stall the scrubber; it resumes once they stop.
    pulse_clr();
    do_write(3'd6, 8'h77, CW'(13'h1000));
    @(negedge clk);
    rd_en = 1'b1; addr = 3'd0; scrub_en = 1'b1;
    repeat (200) @(negedge clk);
    check("stall_valid", 32'(rd_valid), 32'(1));
    check("stall_cnt", {cnt_sec, cnt_ded}, 32'(0));
    rd_en = 1'b0;
    repeat (200) @(negedge clk);
    scrub_en = 1'b0;
    repeat (5) @(negedge clk);
    check("resume_cnt_sec", 32'(cnt_sec), 32'(1));
    do_read(3'd6, r);
    check("resume_fixed", 32'(r), 32'({1'b1, 1'b0, 1'b0, 8'h77}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
